iobus_rect_fill: RTL

Hardware rectangle-fill engine acting as an IOBUS initiator. It fills an axis-aligned rectangle of the 80x60 VGA framebuffer with one colour. It issues the same MMIO transaction pair the wrapper's output decoder already accepts: a write of the pixel address to the VGA address port, then a write of the colour to the VGA colour port. It sits beside OTTERMCU, and an external arbiter muxes its IOBUS outputs onto the wrapper's bus when GRANT is high.

---
 rtl/iobus_rect_fill.sv | 128 ++++++++++++
 1 files changed

// File: rtl/iobus_rect_fill.sv
// Rectangle-fill engine: writes each pixel as a VGA address/colour MMIO pair on IOBUS.
// Optional build macro RECT_CLIP_EN clips the rectangle to the 80x60 visible area at START.
module iobus_rect_fill (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [6:0]  X0,
    input  logic [5:0]  Y0,
    input  logic [6:0]  W,
    input  logic [5:0]  H,
    input  logic [7:0]  COLOR,
    input  logic        GRANT,
    output logic [31:0] IOBUS_ADDR,
    output logic [31:0] IOBUS_OUT,
    output logic        IOBUS_WR,
    output logic        BUSY,
    output logic        DONE
);
    localparam logic [31:0] VGA_ADDR_AD  = 32'h11000120;
    localparam logic [31:0] VGA_COLOR_AD = 32'h11000140;

    typedef enum logic [1:0] {IDLE, WADDR, WCOLOR, FIN} state_t;

    state_t     state;
    logic [6:0] x;
    logic [6:0] x_start;
    logic [6:0] col_left;
    logic [6:0] w_last;
    logic [5:0] y;
    logic [5:0] row_left;
    logic [7:0] color;
    logic [6:0] w_eff;
    logic [5:0] h_eff;

`ifdef RECT_CLIP_EN
    localparam logic [6:0] FB_W = 7'd80;
    localparam logic [5:0] FB_H = 6'd60;

    always_comb begin
        w_eff = '0;
        h_eff = '0;
        if (X0 < FB_W)
            w_eff = (W < (FB_W - X0)) ? W : (FB_W - X0);
        if (Y0 < FB_H)
            h_eff = (H < (FB_H - Y0)) ? H : (FB_H - Y0);
    end
`else
    assign w_eff = W;
    assign h_eff = H;
`endif

    // col_left/row_left count the pixels still to go after the current one.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            x        <= '0;
            x_start  <= '0;
            y        <= '0;
            col_left <= '0;
            row_left <= '0;
            w_last   <= '0;
            color    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        x        <= X0;
                        x_start  <= X0;
                        y        <= Y0;
                        color    <= COLOR;
                        w_last   <= w_eff - 7'd1;
                        col_left <= w_eff - 7'd1;
                        row_left <= h_eff - 6'd1;
                        state    <= ((w_eff == 7'd0) || (h_eff == 6'd0)) ? FIN : WADDR;
                    end
                end
                WADDR: begin
                    if (GRANT)
                        state <= WCOLOR;
                end
                WCOLOR: begin
                    if (GRANT) begin
                        if (col_left != 7'd0) begin
                            x        <= x + 7'd1;
                            col_left <= col_left - 7'd1;
                            state    <= WADDR;
                        end else if (row_left != 6'd0) begin
                            x        <= x_start;
                            y        <= y + 6'd1;
                            col_left <= w_last;
                            row_left <= row_left - 6'd1;
                            state    <= WADDR;
                        end else begin
                            state <= FIN;
                        end
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Bus outputs follow the registered state; the write strobe is gated by GRANT only.
    always_comb begin
        IOBUS_ADDR = '0;
        IOBUS_OUT  = '0;
        IOBUS_WR   = 1'b0;
        BUSY       = 1'b0;
        DONE       = 1'b0;
        case (state)
            WADDR: begin
                IOBUS_ADDR = VGA_ADDR_AD;
                IOBUS_OUT  = {19'b0, y, x};
                IOBUS_WR   = GRANT;
                BUSY       = 1'b1;
            end
            WCOLOR: begin
                IOBUS_ADDR = VGA_COLOR_AD;
                IOBUS_OUT  = {24'b0, color};
                IOBUS_WR   = GRANT;
                BUSY       = 1'b1;
            end
            FIN: DONE = 1'b1;
            default: ;
        endcase
    end
endmodule
